wbuf_seq_ctrl: RTL

- Sequencer for the depthwise weight FIFO in the weight buffer.
- Per channel it loads TAPS kernel weights from the weight load stream into the FIFO, then replays them once per output pixel to the DW PE array, gated by the PE enable.
- It loops over all channels, then reports done.
- It drives the FIFO write/read strobes and a clear pulse; the FIFO datapath itself sits outside this block.

---
 rtl/wbuf_seq_ctrl_pkg.sv | 21 ++
 rtl/wbuf_seq_ctrl_if.sv | 22 ++
 rtl/wbuf_seq_ctrl_loop_cnt.sv | 28 ++
 rtl/wbuf_seq_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/wbuf_seq_ctrl_pkg.sv
// Shared definitions for the depthwise weight-FIFO sequencer:
// default tap count, tap-counter width helper and FSM state encoding.
package wbuf_pkg;

  localparam int TAPS_DEFAULT = 9;

  function automatic int tap_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  localparam int TAP_W = tap_w(TAPS_DEFAULT);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_PLAY  = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_FIN   = 3'd4;

endpackage

// File: rtl/wbuf_seq_ctrl_if.sv
// Load-stream, FIFO-strobe and PE-weight handshake bundle of the sequencer.
// master = sequencer side, slave = load source / FIFO / PE array side.
interface wbuf_seq_if;
  logic ld_valid;
  logic ld_ready;
  logic fifo_wr;
  logic fifo_rd;
  logic fifo_clr;
  logic pe_en;
  logic pe_wvalid;
  logic pe_wlast;

  modport master (
    input  ld_valid, pe_en,
    output ld_ready, fifo_wr, fifo_rd, fifo_clr, pe_wvalid, pe_wlast
  );

  modport slave (
    output ld_valid, pe_en,
    input  ld_ready, fifo_wr, fifo_rd, fifo_clr, pe_wvalid, pe_wlast
  );
endinterface

// File: rtl/wbuf_seq_ctrl_loop_cnt.sv
// Terminal-count loop counter: counts enabled cycles up to a runtime
// terminal value, then wraps to zero. wrap flags the enabled cycle that
// sits on the terminal value, so the compare always precedes the wrap.
module wbuf_loop_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last_val,
  output logic         wrap
);
  logic [W-1:0] cnt;
  logic         at_last;

  assign at_last = (cnt == last_val);
  assign wrap    = en & at_last;

  // Count enabled cycles, wrapping at the terminal value; clear has priority.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_last ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/wbuf_seq_ctrl.sv
// Depthwise weight-FIFO sequencer: per channel loads TAPS weights into the
// FIFO, replays them once per output pixel while the PE array is enabled,
// loops over all channels and then pulses done.
// Optional macro WBUF_PERF_CNT_EN adds stall_cnt / load_cnt counters.
module wbuf_seq_ctrl
  import wbuf_pkg::*;
#(
  parameter int TAPS  = TAPS_DEFAULT,
  parameter int CH_W  = 10,
  parameter int PIX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [CH_W-1:0]  cfg_num_ch,
  input  logic [PIX_W-1:0] cfg_num_pix,
  wbuf_seq_if.master       bus,
  output logic             ch_done,
  output logic             busy,
  output logic             done
`ifdef WBUF_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      load_cnt
`endif
);
  localparam int TAP_BITS = tap_w(TAPS);
  localparam logic [TAP_BITS-1:0] TAP_LAST = TAP_BITS'(TAPS - 1);

  state_t           state;
  state_t           state_nx;
  logic [CH_W-1:0]  num_ch;
  logic [PIX_W-1:0] num_pix;
  logic             start_acc;
  logic             start_zero;
  logic             in_load;
  logic             in_play;
  logic             in_drain;
  logic             fifo_wr;
  logic             fifo_rd;
  logic             tap_wrap;
  logic             pix_wrap;
  logic             ch_wrap;
  logic             vld_p1;
  logic             wlast_p1;

  assign in_load    = (state == ST_LOAD);
  assign in_play    = (state == ST_PLAY);
  assign in_drain   = (state == ST_DRAIN);
  assign start_acc  = (state == ST_IDLE) && cfg_start;
  assign start_zero = (cfg_num_ch == '0) || (cfg_num_pix == '0);

  assign fifo_wr = bus.ld_valid && in_load;
  assign fifo_rd = bus.pe_en && in_play;

  assign bus.ld_ready  = in_load;
  assign bus.fifo_wr   = fifo_wr;
  assign bus.fifo_rd   = fifo_rd;
  // Clear only from IDLE/DRAIN, so it can never collide with a write or read.
  assign bus.fifo_clr  = (start_acc && !start_zero) || (in_drain && !ch_wrap);
  assign bus.pe_wvalid = vld_p1;
  assign bus.pe_wlast  = wlast_p1;

  assign ch_done = in_drain;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_FIN);

  // Job counts are captured once per accepted start and held for the job.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      num_ch  <= cfg_num_ch;
      num_pix <= cfg_num_pix;
    end
  end

  // Tap index: shared by the load phase (writes) and the replay phase (reads).
  wbuf_loop_cnt #(.W(TAP_BITS)) u_tap_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_acc),
    .en       (fifo_wr || fifo_rd),
    .last_val (TAP_LAST),
    .wrap     (tap_wrap)
  );

  // Pixel index: advances when the last tap of a pixel is read.
  wbuf_loop_cnt #(.W(PIX_W)) u_pix_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_acc || in_drain),
    .en       (tap_wrap && in_play),
    .last_val (num_pix - PIX_W'(1)),
    .wrap     (pix_wrap)
  );

  // Channel index: advances once per DRAIN; wrap marks the final channel.
  wbuf_loop_cnt #(.W(CH_W)) u_ch_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_acc),
    .en       (in_drain),
    .last_val (num_ch - CH_W'(1)),
    .wrap     (ch_wrap)
  );

  // Next-state logic for the load / replay / drain channel loop.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (cfg_start) state_nx = start_zero ? ST_FIN : ST_LOAD;
      ST_LOAD:  if (tap_wrap) state_nx = ST_PLAY;
      ST_PLAY:  if (pix_wrap) state_nx = ST_DRAIN;
      ST_DRAIN: state_nx = ch_wrap ? ST_FIN : ST_LOAD;
      ST_FIN:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // State register; reset aborts any job without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // ---- stage p1: FIFO read data is valid one cycle after fifo_rd ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      wlast_p1 <= 1'b0;
    end else begin
      vld_p1   <= fifo_rd;
      wlast_p1 <= tap_wrap && in_play;
    end
  end

`ifdef WBUF_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Saturating stall / load-bubble counters, cleared on each accepted start.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_cnt <= '0;
      load_cnt  <= '0;
    end else begin
      if (in_play && !bus.pe_en)    stall_cnt <= sat_inc(stall_cnt);
      if (in_load && !bus.ld_valid) load_cnt  <= sat_inc(load_cnt);
    end
  end
`endif

endmodule
